// File: rtl/instr_fetch_stage.sv
// RV32I instruction fetch stage: PC register, single-outstanding imem fetch, IF/ID output slot with skid.
// Optional misaligned-redirect fault state enabled by FETCH_MISALIGN_CHECK_EN.
module instr_fetch_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [6:0]            opcode_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  misalign_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [1:0] S_FAULT = 2'd3;
`endif

  logic [1:0]            stateQ;
  logic [ADDR_WIDTH-1:0] pcQ;
  logic                  killQ;
  logic                  validQ;
  logic [DATA_WIDTH-1:0] instrQ;
  logic [ADDR_WIDTH-1:0] pcOutQ;
  logic [ADDR_WIDTH-1:0] pcPlus4Q;
  logic                  skidValid;
  logic [DATA_WIDTH-1:0] skidInstr;
  logic [ADDR_WIDTH-1:0] skidPc;

  logic                  slotFree;
  logic                  consume;
  logic                  accepted;
  logic                  capture;
  logic                  outstanding;
  logic [ADDR_WIDTH-1:0] pcNext;
  logic [ADDR_WIDTH-1:0] redirectTarget;

  assign slotFree    = !validQ || !stall_i;
  assign consume     = validQ && !stall_i;
  assign imem_req_o  = (stateQ == S_REQ) && !skidValid && slotFree;
  assign imem_addr_o = pcQ;
  assign accepted    = imem_req_o && imem_gnt_i;
  assign capture     = (stateQ == S_WAIT) && imem_rvalid_i && !killQ;
  assign pcNext      = pcQ + ADDR_WIDTH'(4);

  // A request is still in flight if it is granted now, or an earlier one has not yet returned.
  assign outstanding = accepted || (((stateQ == S_WAIT) || killQ) && !imem_rvalid_i);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalignQ;
  logic misaligned;
  assign misaligned     = |redirect_pc_i[1:0];
  assign redirectTarget = redirect_pc_i;
  assign misalign_o     = misalignQ;
`else
  assign redirectTarget = redirect_pc_i & ~ADDR_WIDTH'(3);
  assign misalign_o     = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= S_IDLE;
      pcQ       <= RESET_PC;
      killQ     <= 1'b0;
      validQ    <= 1'b0;
      instrQ    <= '0;
      pcOutQ    <= '0;
      pcPlus4Q  <= '0;
      skidValid <= 1'b0;
      skidInstr <= '0;
      skidPc    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalignQ <= 1'b0;
`endif
    end else if (redirect_i) begin
      // Flush everything; a same-cycle response is dropped, an in-flight one is marked for kill.
      pcQ       <= redirectTarget;
      validQ    <= 1'b0;
      skidValid <= 1'b0;
      killQ     <= outstanding;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalignQ <= misaligned;
      if (misaligned) stateQ <= S_FAULT;
      else            stateQ <= outstanding ? S_WAIT : S_REQ;
`else
      stateQ    <= outstanding ? S_WAIT : S_REQ;
`endif
    end else begin
      case (stateQ)
        S_IDLE:  stateQ <= S_REQ;
        S_REQ:   if (accepted) stateQ <= S_WAIT;
        S_WAIT:  if (imem_rvalid_i) stateQ <= S_REQ;
        default: ;
      endcase

      // Killed responses are dropped wherever they land, including the fault state.
      if (imem_rvalid_i && killQ) killQ <= 1'b0;

      if (capture) pcQ <= pcNext;

      if (capture && slotFree) begin
        instrQ   <= imem_rdata_i;
        pcOutQ   <= pcQ;
        pcPlus4Q <= pcNext;
        validQ   <= 1'b1;
      end else if (capture) begin
        skidInstr <= imem_rdata_i;
        skidPc    <= pcQ;
        skidValid <= 1'b1;
      end else if (consume) begin
        if (skidValid) begin
          instrQ    <= skidInstr;
          pcOutQ    <= skidPc;
          pcPlus4Q  <= skidPc + ADDR_WIDTH'(4);
          skidValid <= 1'b0;
        end else begin
          validQ <= 1'b0;
        end
      end
    end
  end

  assign valid_o    = validQ;
  assign instr_o    = instrQ;
  assign opcode_o   = instrQ[6:0];
  assign pc_o       = pcOutQ;
  assign pc_plus4_o = pcPlus4Q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: imem responder with latency control, expected-fetch scoreboard.
// Honours FETCH_MISALIGN_CHECK_EN to match the build of the design.
module tb_instr_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } expItem_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        misalign_o;

  int          total = 0;
  int          bad = 0;
  expItem_t    expQ[$];
  expItem_t    monItem;
  logic [31:0] expPc = 32'h0;
  int          rspLat = 1;
  bit          randLat = 1'b0;
  bit          poisonNext = 1'b0;
  int          rspCnt = 0;
  logic [31:0] rspData = '0;
  int          popCount = 0;

  instr_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .opcode_o      (opcode_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  // Memory contents: address 0 holds 0x00500093; every word keeps opcode 0x13.
  function automatic logic [31:0] memData(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[24:0], 7'b0};
  endfunction

  function automatic logic [31:0] alignTarget(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHECK_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  // Responder: drives rvalid rspLat cycles after a grant, checks fetch order, pushes expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (rspCnt == 1) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = rspData;
      end else begin
        imem_rvalid_i = 1'b0;
      end
      if (rspCnt > 0) rspCnt--;
      #1;
      if (rst_n && imem_req_o && imem_gnt_i) begin
        total++;
        if (imem_addr_o !== expPc) begin
          bad++;
          $display("FAIL fetch_addr got=%h want=%h", imem_addr_o, expPc);
        end
        rspData    = poisonNext ? 32'hDEAD_BEEF : memData(imem_addr_o);
        poisonNext = 1'b0;
        rspCnt     = randLat ? $urandom_range(3, 1) : rspLat;
        if (!redirect_i) begin
          expQ.push_back('{pc: expPc, instr: memData(expPc)});
          expPc = expPc + 32'd4;
        end
      end
      if (rst_n && redirect_i) begin
        expQ.delete();
        expPc = alignTarget(redirect_pc_i);
      end
    end
  end

  // Monitor: every consumed output must match the oldest expected fetch.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && valid_o && !stall_i && !redirect_i) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output pc=%h instr=%h", pc_o, instr_o);
        end else begin
          monItem = expQ.pop_front();
          popCount++;
          if (pc_o !== monItem.pc || instr_o !== monItem.instr) begin
            bad++;
            $display("FAIL out_word pc=%h instr=%h want pc=%h instr=%h",
                     pc_o, instr_o, monItem.pc, monItem.instr);
          end
          total++;
          if (opcode_o !== monItem.instr[6:0] || pc_plus4_o !== monItem.pc + 32'd4) begin
            bad++;
            $display("FAIL out_derived opcode=%h pc4=%h want opcode=%h pc4=%h",
                     opcode_o, pc_plus4_o, monItem.instr[6:0], monItem.pc + 32'd4);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    total++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b0 || misalign_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl valid=%b req=%b mis=%b want 0 0 0", valid_o, imem_req_o, misalign_o);
    end
    total++;
    if (instr_o !== 32'h0 || pc_o !== 32'h0 || pc_plus4_o !== 32'h0 || opcode_o !== 7'h0) begin
      bad++;
      $display("FAIL reset_data instr=%h pc=%h pc4=%h op=%h want 0", instr_o, pc_o, pc_plus4_o, opcode_o);
    end
  endtask

  task automatic test_first_fetch;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    total++;
    if (imem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_req got=%b want=0", imem_req_o);
    end
    @(negedge clk); #2;
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL first_req req=%b addr=%h want 1 00000000", imem_req_o, imem_addr_o);
    end
    @(negedge clk); #2;
    total++;
    if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL wait_cycle req=%b valid=%b want 0 0", imem_req_o, valid_o);
    end
    @(negedge clk); #2;
    total++;
    if (valid_o !== 1'b1 || pc_o !== 32'h0 || opcode_o !== 7'h13 || pc_plus4_o !== 32'h4
        || instr_o !== 32'h0050_0093) begin
      bad++;
      $display("FAIL first_out valid=%b pc=%h op=%h pc4=%h instr=%h want 1 0 13 4 00500093",
               valid_o, pc_o, opcode_o, pc_plus4_o, instr_o);
    end
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      bad++;
      $display("FAIL second_req req=%b addr=%h want 1 00000004", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_stall;
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_o && pc_o == 32'h4) begin
        stall_i = 1'b1;
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL stall_setup timeout got=0 want=1");
    end
    for (int i = 0; i < 5; i++) begin
      #2;
      total++;
      if (valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== memData(32'h4) || imem_req_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d valid=%b pc=%h instr=%h req=%b want 1 4 %h 0",
                 i, valid_o, pc_o, instr_o, imem_req_o, memData(32'h4));
      end
      @(negedge clk);
    end
    stall_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      if (valid_o) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found || pc_o !== 32'h8) begin
      bad++;
      $display("FAIL stall_release found=%b pc=%h want 1 00000008", found, pc_o);
    end
  endtask

  task automatic test_redirect_kill;
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_o) begin
        rspLat = 3;
        poisonNext = 1'b1;
        found = 1'b1;
        break;
      end
    end
    @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    rspLat = 1;
    @(negedge clk);
    redirect_i = 1'b0;
    #2;
    total++;
    if (!found || valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL kill_wait found=%b valid=%b req=%b want 1 0 0", found, valid_o, imem_req_o);
    end
    @(negedge clk); #2;
    total++;
    if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      bad++;
      $display("FAIL kill_drop valid=%b req=%b want 0 0", valid_o, imem_req_o);
    end
    @(negedge clk); #2;
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL kill_resume req=%b addr=%h valid=%b want 1 00000100 0", imem_req_o, imem_addr_o, valid_o);
    end
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      if (valid_o) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found || pc_o !== 32'h100 || instr_o !== memData(32'h100)) begin
      bad++;
      $display("FAIL kill_first found=%b pc=%h instr=%h want 1 00000100 %h", found, pc_o, instr_o, memData(32'h100));
    end
  endtask

  task automatic test_redirect_rvalid_stall;
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_o) begin
        found = 1'b1;
        break;
      end
    end
    @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    stall_i = 1'b1;
    @(negedge clk);
    redirect_i = 1'b0;
    #2;
    total++;
    if (!found || valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
      bad++;
      $display("FAIL same_cycle_drop found=%b valid=%b req=%b addr=%h want 1 0 1 00000040",
               found, valid_o, imem_req_o, imem_addr_o);
    end
    @(negedge clk);
    stall_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (valid_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!found || pc_o !== 32'h40) begin
      bad++;
      $display("FAIL same_cycle_resume found=%b pc=%h want 1 00000040", found, pc_o);
    end
  endtask

  task automatic test_wrap;
    bit found = 1'b0;
    @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (valid_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!found || pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
      bad++;
      $display("FAIL wrap_out found=%b pc=%h pc4=%h want 1 fffffffc 00000000", found, pc_o, pc_plus4_o);
    end
    total++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      bad++;
      $display("FAIL wrap_next req=%b addr=%h want 1 00000000", imem_req_o, imem_addr_o);
    end
  endtask

  task automatic test_misalign;
    bit found = 1'b0;
    @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h102;
    @(negedge clk);
    redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 10; i++) begin
      #2;
      total++;
      if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || valid_o !== 1'b0) begin
        bad++;
        $display("FAIL fault_hold cyc=%0d mis=%b req=%b valid=%b want 1 0 0", i, misalign_o, imem_req_o, valid_o);
      end
      @(negedge clk);
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    @(negedge clk);
    redirect_i = 1'b0;
    #2;
    total++;
    if (misalign_o !== 1'b0) begin
      bad++;
      $display("FAIL fault_clear mis=%b want 0", misalign_o);
    end
    for (int i = 0; i < 10; i++) begin
      if (valid_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk); #2;
    end
    total++;
    if (!found || pc_o !== 32'h200) begin
      bad++;
      $display("FAIL fault_resume found=%b pc=%h want 1 00000200", found, pc_o);
    end
`else
    #2;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk); #2;
    end
    total++;
    if (!found || imem_addr_o !== 32'h100 || misalign_o !== 1'b0) begin
      bad++;
      $display("FAIL align_redirect found=%b addr=%h mis=%b want 1 00000100 0", found, imem_addr_o, misalign_o);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int startPops = popCount;
    randLat = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      stall_i    = ($urandom_range(3, 0) == 0);
      imem_gnt_i = ($urandom_range(3, 0) != 0);
    end
    @(negedge clk);
    stall_i    = 1'b0;
    imem_gnt_i = 1'b1;
    randLat    = 1'b0;
    repeat (12) @(negedge clk);
    #3;
    total++;
    if (popCount - startPops < 30) begin
      bad++;
      $display("FAIL b2b_progress got=%0d want>=30", popCount - startPops);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_kill();
    test_redirect_rvalid_stall();
    test_wrap();
    test_misalign();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
